// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the stage registers and pipe_hazard_ctrl.
// The controller takes the master modport; the stage/memory side takes slave.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             idex_mem_read;
    logic [4:0]       idex_rt;
    logic [4:0]       ifid_rs;
    logic [4:0]       ifid_rt;
    logic             branch_taken;
    logic             exmem_mem_access;
    logic             dmem_ready;
    logic             dmem_req;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_hold;
    logic             memwb_bubble;
    logic             mem_error;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        input  idex_mem_read, idex_rt, ifid_rs, ifid_rt,
        input  branch_taken, exmem_mem_access, dmem_ready,
        output dmem_req, pc_write, ifid_write, ifid_flush,
        output idex_flush, exmem_hold, memwb_bubble,
        output mem_error, stall_cycles
    );

    modport slave (
        output idex_mem_read, idex_rt, ifid_rs, ifid_rt,
        output branch_taken, exmem_mem_access, dmem_ready,
        input  dmem_req, pc_write, ifid_write, ifid_flush,
        input  idex_flush, exmem_hold, memwb_bubble,
        input  mem_error, stall_cycles
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use, branch flush and dmem wait states.
// Optional stall counter enabled by defining HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic                clock,
    input  logic                reset,
    pipe_hazard_ctrl_if.master  hz
);
    localparam int WCW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

    typedef enum logic {
        RUN,
        MEM_WAIT
    } state_t;

    state_t         r_state;
    logic [WCW-1:0] r_wcnt;
    logic           r_mem_error;

    logic w_timeout;
    logic w_memstall;
    logic w_loaduse;
    logic w_pc_write;
    logic w_ifid_write;
    logic w_ifid_flush;
    logic w_idex_flush;
    logic w_exmem_hold;
    logic w_memwb_bubble;
    logic w_dmem_req;

    assign w_timeout = (r_state == MEM_WAIT)
                     && (MEM_TIMEOUT != 0)
                     && (r_wcnt == WCW'(MEM_TIMEOUT));

    assign w_memstall = hz.exmem_mem_access
                      & ~hz.dmem_ready
                      & ~w_timeout;

    assign w_loaduse = hz.idex_mem_read
                     & (hz.idex_rt != 5'd0)
                     & ((hz.idex_rt == hz.ifid_rs)
                      | (hz.idex_rt == hz.ifid_rt));

    // Ordered priority: memstall > branch > load-use > normal flow.
    always_comb begin
        w_pc_write     = 1'b0;
        w_ifid_write   = 1'b0;
        w_ifid_flush   = 1'b0;
        w_idex_flush   = 1'b0;
        w_exmem_hold   = 1'b0;
        w_memwb_bubble = 1'b0;
        w_dmem_req     = 1'b0;
        if (!reset) begin
            w_dmem_req = hz.exmem_mem_access;
            if (w_memstall) begin
                w_exmem_hold   = 1'b1;
                w_memwb_bubble = 1'b1;
            end else if (hz.branch_taken) begin
                w_pc_write   = 1'b1;
                w_ifid_write = 1'b1;
                w_ifid_flush = 1'b1;
                w_idex_flush = 1'b1;
            end else if (w_loaduse) begin
                w_idex_flush = 1'b1;
            end else begin
                w_pc_write   = 1'b1;
                w_ifid_write = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= RUN;
            r_wcnt      <= '0;
            r_mem_error <= 1'b0;
        end else begin
            if (w_timeout) begin
                r_mem_error <= 1'b1;
            end
            case (r_state)
                RUN: begin
                    if (w_memstall) begin
                        r_state <= MEM_WAIT;
                        r_wcnt  <= WCW'(1);
                    end
                end
                MEM_WAIT: begin
                    if (w_memstall) begin
                        r_wcnt <= r_wcnt + WCW'(1);
                    end else begin
                        r_state <= RUN;
                        r_wcnt  <= '0;
                    end
                end
                default: begin
                    r_state <= RUN;
                    r_wcnt  <= '0;
                end
            endcase
        end
    end

    assign hz.pc_write     = w_pc_write;
    assign hz.ifid_write   = w_ifid_write;
    assign hz.ifid_flush   = w_ifid_flush;
    assign hz.idex_flush   = w_idex_flush;
    assign hz.exmem_hold   = w_exmem_hold;
    assign hz.memwb_bubble = w_memwb_bubble;
    assign hz.dmem_req     = w_dmem_req;
    assign hz.mem_error    = r_mem_error;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (!w_pc_write && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign hz.stall_cycles = r_stall_cnt;
`else
    assign hz.stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: vector table plus multi-cycle
// memory-wait, timeout, protocol-drop and reset sequences.
module tb_pipe_hazard_ctrl;
    localparam int CW = 4;

    // {pc_write, ifid_write, ifid_flush, idex_flush, exmem_hold, memwb_bubble, dmem_req}
    localparam logic [6:0] NORM = 7'b1100000;
    localparam logic [6:0] LU   = 7'b0001000;
    localparam logic [6:0] BR   = 7'b1111000;
    localparam logic [6:0] MS   = 7'b0000111;
    localparam logic [6:0] REQ  = 7'b0000001;

    typedef struct {
        logic       mr;
        logic [4:0] rt;
        logic [4:0] rs;
        logic [4:0] rtid;
        logic       br;
        logic       acc;
        logic       rdy;
        logic [6:0] exp;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   exp_stall = 0;
    vec_t vecs[12];

    pipe_hazard_ctrl_if #(.CNT_W(CW)) hz ();

    pipe_hazard_ctrl #(
        .MEM_TIMEOUT(15),
        .CNT_W(CW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .hz(hz)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic int exp_sc();
`ifdef HAZARD_PERF_CNT_EN
        return exp_stall;
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [6:0] bundle();
        return {hz.pc_write, hz.ifid_write, hz.ifid_flush, hz.idex_flush,
                hz.exmem_hold, hz.memwb_bubble, hz.dmem_req};
    endfunction

    task automatic drive(input logic mr, input logic [4:0] rt,
                         input logic [4:0] rs, input logic [4:0] rtid,
                         input logic br, input logic acc, input logic rdy);
        hz.idex_mem_read    = mr;
        hz.idex_rt          = rt;
        hz.ifid_rs          = rs;
        hz.ifid_rt          = rtid;
        hz.branch_taken     = br;
        hz.exmem_mem_access = acc;
        hz.dmem_ready       = rdy;
    endtask

    // Check outputs mid-cycle, then advance one edge and update the model.
    task automatic step(input string nm, input logic [6:0] exp);
        @(negedge clock);
        chk(nm, 32'(bundle()), 32'(exp));
        @(posedge clock);
        #1;
        if (!exp[6] && exp_stall != 15) exp_stall++;
    endtask

    initial begin
        vecs[0]  = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, NORM};
        vecs[1]  = '{1'b1, 5'd8,  5'd8,  5'd0,  1'b0, 1'b0, 1'b0, LU};
        vecs[2]  = '{1'b0, 5'd8,  5'd8,  5'd0,  1'b0, 1'b0, 1'b0, NORM};
        vecs[3]  = '{1'b1, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, NORM};
        vecs[4]  = '{1'b1, 5'd8,  5'd3,  5'd8,  1'b0, 1'b0, 1'b0, LU};
        vecs[5]  = '{1'b1, 5'd8,  5'd9,  5'd10, 1'b0, 1'b0, 1'b0, NORM};
        vecs[6]  = '{1'b1, 5'd8,  5'd8,  5'd0,  1'b1, 1'b0, 1'b0, BR};
        vecs[7]  = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b1, 1'b0, 1'b0, BR};
        vecs[8]  = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b1, 1'b1, NORM | REQ};
        vecs[9]  = '{1'b1, 5'd5,  5'd5,  5'd0,  1'b0, 1'b1, 1'b1, LU | REQ};
        vecs[10] = '{1'b0, 5'd31, 5'd31, 5'd0,  1'b0, 1'b0, 1'b0, NORM};
        vecs[11] = '{1'b1, 5'd31, 5'd0,  5'd31, 1'b0, 1'b0, 1'b0, LU};

        // Reset: inputs that would otherwise stall and request memory
        drive(1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b1, 1'b0);
        #12;
        chk("reset_outputs", 32'(bundle()), 32'd0);
        chk("reset_mem_error", 32'(hz.mem_error), 32'd0);
        chk("reset_stall", 32'(hz.stall_cycles), 32'(exp_sc()));
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].mr, vecs[i].rt, vecs[i].rs, vecs[i].rtid,
                  vecs[i].br, vecs[i].acc, vecs[i].rdy);
            step($sformatf("vec%0d", i), vecs[i].exp);
        end
        chk("stall_after_table", 32'(hz.stall_cycles), 32'(exp_sc()));

        // Memory wait of 4 cycles; branch held in frozen EX is ignored
        drive(1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step($sformatf("memwait%0d", i), MS);
        hz.dmem_ready = 1'b1;
        step("mem_release_branch", BR | REQ);
        chk("stall_after_wait", 32'(hz.stall_cycles), 32'(exp_sc()));
        chk("no_error_after_wait", 32'(hz.mem_error), 32'd0);

        // Timeout: ready never arrives, release on the 16th cycle
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 15; i++) step($sformatf("tmo_wait%0d", i), MS);
        chk("pre_timeout_error", 32'(hz.mem_error), 32'd0);
        step("timeout_release", NORM | REQ);
        chk("timeout_error_set", 32'(hz.mem_error), 32'd1);
        chk("stall_saturated", 32'(hz.stall_cycles), 32'(exp_sc()));
        hz.exmem_mem_access = 1'b0;
        step("post_timeout0", NORM);
        step("post_timeout1", NORM);
        chk("error_sticky", 32'(hz.mem_error), 32'd1);

        // Access dropped during MEM_WAIT counts as a release
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        step("drop_wait0", MS);
        step("drop_wait1", MS);
        hz.exmem_mem_access = 1'b0;
        step("drop_release", NORM);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
        step("drop_after", NORM | REQ);

        // Reset in the middle of a wait (wcnt=3)
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step($sformatf("rst_wait%0d", i), MS);
        #2;
        reset = 1'b1;
        #1;
        exp_stall = 0;
        chk("midwait_reset_outputs", 32'(bundle()), 32'd0);
        chk("midwait_reset_error", 32'(hz.mem_error), 32'd0);
        chk("midwait_reset_stall", 32'(hz.stall_cycles), 32'(exp_sc()));
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        hz.exmem_mem_access = 1'b0;
        step("after_reset_run", NORM);
        chk("after_reset_error", 32'(hz.mem_error), 32'd0);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        step("after_reset_stall", MS);
        hz.dmem_ready = 1'b1;
        step("after_reset_release", NORM | REQ);
        chk("after_reset_count", 32'(hz.stall_cycles), 32'(exp_sc()));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core.
- Drives write-enable, flush and hold controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB stage registers.
- Resolves load-use hazards, taken-branch flushes and data-memory wait states (dmem_req/dmem_ready handshake with timeout).
- Sits beside the stage registers in the top level; all stage registers consume its outputs on the same clock edge.

Parameters:
- MEM_TIMEOUT, 15: max consecutive MEM_WAIT cycles before forced release; 0 disables timeout.
- CNT_W, 16: width of stall performance counter.

Ports:
- clock  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-high reset
- idex_mem_read  in  1  instruction in EX is a load
- idex_rt  in  5  load destination register in EX
- ifid_rs  in  5  rs of instruction in ID
- ifid_rt  in  5  rt of instruction in ID
- branch_taken  in  1  branch/jump resolved taken in EX
- exmem_mem_access  in  1  instruction in MEM is a load or store
- dmem_ready  in  1  data memory completes access this cycle
- dmem_req  out  1  data memory access request
- pc_write  out  1  PC update enable
- ifid_write  out  1  IF/ID load enable
- ifid_flush  out  1  IF/ID clear to NOP
- idex_flush  out  1  ID/EX clear to bubble
- exmem_hold  out  1  EX/MEM hold current contents
- memwb_bubble  out  1  MEM/WB captures bubble (write enable 0)
- mem_error  out  1  sticky memory-timeout flag
- stall_cycles  out  CNT_W  saturating count of cycles with pc_write=0

Behaviour:
- State register: RUN, MEM_WAIT. Wait counter wcnt, width clog2(MEM_TIMEOUT+1), minimum 1 bit.
- Reset (async, while asserted): state=RUN, wcnt=0, mem_error=0, stall_cycles=0.
- Reset: pc_write, ifid_write, ifid_flush, idex_flush, exmem_hold, memwb_bubble and dmem_req forced to 0.
- Combinational signals:
  - memstall = exmem_mem_access & ~dmem_ready & ~timeout.
  - timeout = (state==MEM_WAIT) & (MEM_TIMEOUT!=0) & (wcnt==MEM_TIMEOUT).
  - loaduse = idex_mem_read & (idex_rt!=0) & (idex_rt==ifid_rs | idex_rt==ifid_rt).
- Priority, highest first:
  - memstall: pc_write=0, ifid_write=0, exmem_hold=1, memwb_bubble=1, idex_flush=0, ifid_flush=0. ID/EX is also held, via pc_write=0 reused as the ID/EX enable.
  - branch_taken: ifid_flush=1, idex_flush=1, pc_write=1, ifid_write=1; loaduse ignored.
  - loaduse: pc_write=0, ifid_write=0, idex_flush=1 for exactly one cycle (the load advances to MEM next edge).
  - otherwise: pc_write=1, ifid_write=1, all flush/hold/bubble=0.
- dmem_req = exmem_mem_access (not in reset). Stays high through MEM_WAIT.
- Transitions:
  - RUN -> MEM_WAIT when memstall; wcnt<=1.
  - MEM_WAIT stays while memstall; wcnt increments.
  - MEM_WAIT -> RUN on dmem_ready=1 or timeout; wcnt<=0.
- Timeout: the timeout cycle behaves as a ready cycle (pipeline released) and sets mem_error<=1 on that edge. mem_error clears only on reset.
- dmem_ready and branch_taken in the same MEM_WAIT cycle: released, branch flush applied that cycle. During a memstall, branch_taken is held in frozen EX and re-evaluated after release.
- exmem_mem_access=0 in MEM_WAIT: treated as release. This is a protocol violation; no error is raised.
- stall_cycles increments on each edge where pc_write=0 and reset=0. It saturates at all-ones.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined: stall_cycles counter as above.
- Undefined: no counter flops; stall_cycles tied to 0.

Test Plan:
- Reset mid-MEM_WAIT: assert reset while wcnt=3 -> outputs 0 immediately, state RUN, mem_error=0 after release.
- Load-use: idex_mem_read=1, idex_rt=8, ifid_rs=8 -> one cycle pc_write=0, ifid_write=0, idex_flush=1; next cycle normal. Repeat with idex_rt=0 -> no stall.
- Branch vs load-use: branch_taken=1 together with loaduse condition -> ifid_flush=1, idex_flush=1, pc_write=1.
- Memory wait: exmem_mem_access=1, dmem_ready low 4 cycles then high -> exmem_hold=1 and memwb_bubble=1 for 4 cycles, release on 5th. stall_cycles=4 (with HAZARD_PERF_CNT_EN).
- Timeout: MEM_TIMEOUT=15, dmem_ready held 0 -> release on cycle 16, mem_error=1 and sticky until reset.
- Counter saturation: CNT_W=4, 20 stall cycles -> stall_cycles=15.
